// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit slice.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package lsu_pkg;

  // Default data memory depth in 32-bit words.
  localparam int MEM_WORDS_DEFAULT = 1024;

  // RV32I load/store funct3 width/sign codes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4,
    ERR      = 3'd5
  } lsu_state_e;

  // Unsigned variants only make sense for loads; stores have no extension.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = is_store;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Natural alignment check; bytes are always aligned.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = lo[0];
      F3_W:        mis = (lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_ops.sv
// lsu_lane_ops: byte/half lane extraction with extension for loads, and
// lane merge into an existing word for sub-word stores.
// Latency: combinational. Backpressure: none.
// Ports: word_i (memory word), lane_i (addr[1:0]), funct3_i, wdata_i (store data)
//        -> load_data_o (extended load result), store_word_o (merged word).
import lsu_pkg::*;

module lsu_lane_ops (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word_i >> {lane_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = lane_i[1] ? word_i[31:16] : word_i[15:0];

    load_data_o = word_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data_o = {24'h0, byte_v};
      F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data_o = {16'h0, half_v};
      default: load_data_o = word_i;
    endcase

    // Only the addressed lane is replaced; the rest keeps memory contents.
    store_word_o = word_i;
    case (funct3_i)
      F3_B: store_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (lane_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else           store_word_o[15:0]  = wdata_i[15:0];
      end
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte-addressed load/store front end for a
// word-addressed single-port memory (comb read, write on negedge).
// Latency: load 2, SW 2, SB/SH 3 (read-modify-write), error 1 cycle from accept.
// Backpressure: req_ready only in IDLE; one request in flight, never dropped.
// Ports: req_* CPU request handshake, resp_* one-cycle response pulse with
//        status flags, mem_* word memory interface driven from registered state.
import lsu_pkg::*;

module load_store_unit #(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // One bit wider than the address so the limit itself is representable.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * MEM_WORDS);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              store_q, store_d;
  logic              mis_q, mis_d;
  logic              fault_q, fault_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wbuf_q, wbuf_d;

  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        req_fault;
  logic        req_mis;

  lsu_lane_ops u_lane_ops (
    .word_i       (mem_rdata),
    .lane_i       (addr_q[1:0]),
    .funct3_i     (f3_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  // Fault has priority: a faulting request never also reports misaligned.
  always_comb begin
    req_fault = f3_illegal(req_is_store, req_funct3) ||
                ({1'b0, req_addr} >= ADDR_LIMIT);
    req_mis   = !req_fault && f3_misaligned(req_funct3, req_addr[1:0]);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    store_d = store_q;
    mis_d   = mis_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    wbuf_d  = wbuf_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          store_d = req_is_store;
          mis_d   = req_mis;
          fault_d = req_fault;
          rdata_d = 32'h0;  // stores and errors respond with zero data
          if (req_fault || req_mis)   state_d = ERR;
          else if (!req_is_store)     state_d = LOAD;
          else if (req_funct3 == F3_W) state_d = WRITE;
          else                        state_d = RMW_READ;
        end
      end
      LOAD: begin
        rdata_d = load_data;
        state_d = RESP;
      end
      RMW_READ: begin
        wbuf_d  = store_word;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= 3'b000;
      wdata_q <= 32'h0;
      store_q <= 1'b0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
      wbuf_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      wbuf_q  <= wbuf_d;
    end
  end

  // All outputs decode registered state only, so memory-side signals are
  // stable across the negedge write strobe.
  always_comb begin
    req_ready       = (state_q == IDLE);
    resp_valid      = (state_q == RESP) || (state_q == ERR);
    resp_rdata      = (state_q == RESP) ? rdata_q : 32'h0;
    resp_misaligned = (state_q == ERR) && mis_q;
    resp_fault      = (state_q == ERR) && fault_q;
    mem_addr        = {2'b00, addr_q[ADDR_W-1:2]};
    mem_write       = (state_q == WRITE) && store_q;
    mem_wdata       = 32'h0;
    if (state_q == WRITE)
      mem_wdata = (f3_q == F3_W) ? wdata_q : wbuf_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  // Data memory: combinational read, write on negedge.
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  assign mem_rdata = mem[mem_addr[9:0]];
  always @(negedge clk) if (mem_write) mem[mem_addr[9:0]] = mem_wdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Reference: behaviour of one request from the RV32I rules, updating ref_mem.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic mis, output logic flt, output int lat,
                                output int nwr, output logic [31:0] waddr,
                                output logic [31:0] wword);
    int size, idx, shift;
    logic [31:0] word, v, mask;
    flt = (f3 == 3 || f3 == 6 || f3 == 7) || (st && (f3 == 4 || f3 == 5)) || (a >= 32'd4096);
    size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    mis = !flt && ((a % size) != 0);
    rd = 0; nwr = 0; waddr = 0; wword = 0;
    if (flt || mis) begin
      lat = 1;
    end else begin
      idx = int'(a / 4);
      shift = 8 * int'(a % 4);
      word = ref_mem[idx];
      if (!st) begin
        v = word >> shift;
        if (size == 1) begin
          v = v & 32'hFF;
          if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
        end
        rd = v;
        lat = 2;
      end else begin
        mask = (size == 4) ? 32'hFFFFFFFF : (size == 2) ? (32'hFFFF << shift) : (32'hFF << shift);
        wword = (word & ~mask) | ((wd << shift) & mask);
        ref_mem[idx] = wword;
        nwr = 1;
        waddr = a / 4;
        lat = (size == 4) ? 2 : 3;
      end
    end
  endfunction

  // Drives one request and observes its full response window.
  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic mis, output logic flt, output int nwr,
                       output logic [31:0] waddr, output logic [31:0] wword);
    int guard;
    bit found;
    lat = -1; rd = 0; mis = 0; flt = 0; nwr = 0; waddr = 0; wword = 0;
    @(negedge clk);
    req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++; failures++;
      $display("FAIL accept_timeout addr=%h req_ready never high", a);
      req_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    found = 0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_write) begin
        nwr++; waddr = mem_addr; wword = mem_wdata;
      end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; mis = resp_misaligned; flt = resp_fault;
        found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL resp_timeout addr=%h no resp_valid within 10 cycles", a);
    end
  endtask

  task automatic test_reset;
    reset = 1; req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
        resp_misaligned !== 1'b0 || resp_fault !== 1'b0 || mem_write !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b rd=%h mis=%b flt=%b we=%b ma=%h wd=%h want 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault, mem_write, mem_addr, mem_wdata);
    end
    reset = 0;
  endtask

  task automatic test_loads;
    int lat, nwr; logic [31:0] rd, wa, ww; logic mis, flt;
    mem[5] = 32'h8899AABB; ref_mem[5] = 32'h8899AABB;
    issue(0, 3'b010, 32'h14, 0, lat, rd, mis, flt, nwr, wa, ww);
    checks++;
    if (lat !== 2 || rd !== 32'h8899AABB || mis !== 0 || flt !== 0 || nwr !== 0) begin
      failures++;
      $display("FAIL lw_word got lat=%0d rd=%h mis=%b flt=%b nwr=%0d want 2 8899aabb 0 0 0", lat, rd, mis, flt, nwr);
    end
    issue(0, 3'b000, 32'h17, 0, lat, rd, mis, flt, nwr, wa, ww);
    checks++;
    if (rd !== 32'hFFFFFF88 || lat !== 2) begin failures++; $display("FAIL lb_sign got rd=%h lat=%0d want ffffff88 2", rd, lat); end
    issue(0, 3'b100, 32'h17, 0, lat, rd, mis, flt, nwr, wa, ww);
    checks++;
    if (rd !== 32'h00000088) begin failures++; $display("FAIL lbu_zero got %h want 00000088", rd); end
    issue(0, 3'b001, 32'h16, 0, lat, rd, mis, flt, nwr, wa, ww);
    checks++;
    if (rd !== 32'hFFFF8899) begin failures++; $display("FAIL lh_sign got %h want ffff8899", rd); end
    issue(0, 3'b101, 32'h14, 0, lat, rd, mis, flt, nwr, wa, ww);
    checks++;
    if (rd !== 32'h0000AABB) begin failures++; $display("FAIL lhu_zero got %h want 0000aabb", rd); end
  endtask

  task automatic test_store_byte;
    int lat, nwr; logic [31:0] rd, wa, ww; logic mis, flt;
    issue(1, 3'b000, 32'h15, 32'h12345677, lat, rd, mis, flt, nwr, wa, ww);
    ref_mem[5] = 32'h889977BB;
    checks++;
    if (nwr !== 1 || wa !== 32'd5 || ww !== 32'h889977BB || lat !== 3 || rd !== 0 || mis !== 0 || flt !== 0) begin
      failures++;
      $display("FAIL sb_rmw got nwr=%0d addr=%h wdata=%h lat=%0d rd=%h want 1 5 889977bb 3 0", nwr, wa, ww, lat, rd);
    end
    issue(0, 3'b010, 32'h14, 0, lat, rd, mis, flt, nwr, wa, ww);
    checks++;
    if (rd !== 32'h889977BB) begin failures++; $display("FAIL sb_readback got %h want 889977bb", rd); end
  endtask

  task automatic test_errors;
    int lat, nwr; logic [31:0] rd, wa, ww; logic mis, flt;
    issue(0, 3'b001, 32'h15, 0, lat, rd, mis, flt, nwr, wa, ww);
    checks++;
    if (lat !== 1 || mis !== 1 || flt !== 0 || rd !== 0 || nwr !== 0) begin
      failures++;
      $display("FAIL lh_misaligned got lat=%0d mis=%b flt=%b rd=%h nwr=%0d want 1 1 0 0 0", lat, mis, flt, rd, nwr);
    end
    issue(1, 3'b010, 32'h1000, 32'hDEADBEEF, lat, rd, mis, flt, nwr, wa, ww);
    checks++;
    if (lat !== 1 || mis !== 0 || flt !== 1 || rd !== 0 || nwr !== 0) begin
      failures++;
      $display("FAIL sw_range_fault got lat=%0d mis=%b flt=%b rd=%h nwr=%0d want 1 0 1 0 0", lat, mis, flt, rd, nwr);
    end
    issue(0, 3'b011, 32'h14, 0, lat, rd, mis, flt, nwr, wa, ww);
    checks++;
    if (lat !== 1 || mis !== 0 || flt !== 1 || rd !== 0 || nwr !== 0) begin
      failures++;
      $display("FAIL f3_011_fault got lat=%0d mis=%b flt=%b rd=%h nwr=%0d want 1 0 1 0 0", lat, mis, flt, rd, nwr);
    end
  endtask

  task automatic test_reset_mid_rmw;
    int bad;
    bad = 0;
    @(negedge clk);
    req_valid = 1; req_is_store = 1; req_funct3 = 3'b001; req_addr = 32'h16; req_wdata = 32'h0000FFFF;
    @(posedge clk);  // accepted from IDLE
    #1;
    req_valid = 0;
    reset = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_rmw_ready got rdy=%b we=%b want 1 0", req_ready, mem_write);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (mem_write !== 0 || resp_valid !== 0 || req_ready !== 1) bad++;
    end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_write !== 0 || resp_valid !== 0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL reset_rmw_quiet got %0d bad cycles want 0", bad); end
    checks++;
    if (mem[5] !== 32'h889977BB) begin failures++; $display("FAIL reset_rmw_mem got %h want 889977bb", mem[5]); end
  endtask

  task automatic test_back_to_back;
    int gap, acc_gap, guard;
    bit accepted, ready_seen;
    mem[4] = 32'h13572468; ref_mem[4] = 32'h13572468;
    @(negedge clk);
    req_valid = 1; req_is_store = 0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = 0;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h10;  // second request held valid from here on
    guard = 0;
    while (!resp_valid && guard < 10) begin @(negedge clk); guard++; end
    checks++;
    if (resp_valid !== 1 || req_ready !== 0 || resp_rdata !== ref_mem[5]) begin
      failures++;
      $display("FAIL b2b_first got vld=%b rdy=%b rd=%h want 1 0 %h", resp_valid, req_ready, resp_rdata, ref_mem[5]);
    end
    gap = 0; acc_gap = 0; accepted = 0;
    while (gap < 10) begin
      ready_seen = req_ready;
      @(negedge clk);
      gap++;
      if (ready_seen && !accepted) begin accepted = 1; acc_gap = gap; req_valid = 0; end
      if (resp_valid) break;
    end
    req_valid = 0;
    checks++;
    if (acc_gap !== 2 || gap !== 3) begin
      failures++;
      $display("FAIL b2b_timing got accept=%0d resp=%0d want 2 3", acc_gap, gap);
    end
    checks++;
    if (resp_rdata !== 32'h13572468) begin failures++; $display("FAIL b2b_second got %h want 13572468", resp_rdata); end
  endtask

  task automatic test_random;
    logic [2:0] legal [5];
    int lat, nwr, e_lat, e_nwr;
    logic [31:0] rd, wa, ww, e_rd, e_wa, e_ww, a, wd;
    logic mis, flt, e_mis, e_flt;
    logic [2:0] f3;
    bit st;
    legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010; legal[3] = 3'b100; legal[4] = 3'b101;
    for (int w = 0; w < 16; w++) begin
      mem[w] = $urandom; ref_mem[w] = mem[w];
    end
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 32'hFFFF) : $urandom_range(0, 63);
      wd = $urandom;
      model(st, f3, a, wd, e_rd, e_mis, e_flt, e_lat, e_nwr, e_wa, e_ww);
      issue(st, f3, a, wd, lat, rd, mis, flt, nwr, wa, ww);
      checks++;
      if (lat !== e_lat || rd !== e_rd || mis !== e_mis || flt !== e_flt || nwr !== e_nwr) begin
        failures++;
        $display("FAIL rand_resp n=%0d st=%b f3=%0d a=%h got lat=%0d rd=%h mis=%b flt=%b nwr=%0d want %0d %h %b %b %0d",
                 n, st, f3, a, lat, rd, mis, flt, nwr, e_lat, e_rd, e_mis, e_flt, e_nwr);
      end
      if (e_nwr == 1) begin
        checks++;
        if (wa !== e_wa || ww !== e_ww) begin
          failures++;
          $display("FAIL rand_write n=%0d got addr=%h data=%h want %h %h", n, wa, ww, e_wa, e_ww);
        end
      end
    end
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (mem[w] !== ref_mem[w]) begin
        failures++;
        $display("FAIL rand_mem word=%0d got %h want %h", w, mem[w], ref_mem[w]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    test_reset();
    test_loads();
    test_store_byte();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
